// File: rtl/soil_moisture_pkg.sv
// rtl/soil_moisture_pkg.sv - shared encodings and defaults for the soil moisture frontend
package soil_moisture_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_COMPARE = 2'd3
    } meas_state_t;

    // Defaults shared with the irrigation FSM
    localparam int DEF_ADC_WIDTH        = 10;
    localparam int DEF_NUM_SAMPLES_LOG2 = 2;
    localparam int DEF_LOW_THRESH       = 300;
    localparam int DEF_HIGH_THRESH      = 400;
    localparam int DEF_TIMEOUT_CYCLES   = 1024;

    // moisture_low polarity: 1 means dry soil, pump needed
    localparam logic MOISTURE_DRY = 1'b1;
    localparam logic MOISTURE_WET = 1'b0;

endpackage

// File: rtl/moisture_hysteresis_cmp.sv
// rtl/moisture_hysteresis_cmp.sv - hysteresis decision for the moisture_low flag
module moisture_hysteresis_cmp
    import soil_moisture_pkg::*;
#(
    parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
    parameter int LOW_THRESH  = DEF_LOW_THRESH,
    parameter int HIGH_THRESH = DEF_HIGH_THRESH
) (
    input  logic [ADC_WIDTH-1:0] i_avg,
    input  logic                 i_prev_low,
    output logic                 o_next_low
);

    localparam logic [ADC_WIDTH-1:0] LOW_T  = ADC_WIDTH'(LOW_THRESH);
    localparam logic [ADC_WIDTH-1:0] HIGH_T = ADC_WIDTH'(HIGH_THRESH);

    // Set below the low band edge, clear at or above the high edge, otherwise hold
    always_comb begin
        o_next_low = i_prev_low;
        if (i_avg < LOW_T) begin
            o_next_low = MOISTURE_DRY;
        end else if (i_avg >= HIGH_T) begin
            o_next_low = MOISTURE_WET;
        end
    end

endmodule

// File: rtl/soil_moisture_sensor_frontend.sv
// rtl/soil_moisture_sensor_frontend.sv - averaged ADC measurement producing the moisture_low flag
module soil_moisture_sensor_frontend
    import soil_moisture_pkg::*;
#(
    parameter int ADC_WIDTH        = DEF_ADC_WIDTH,
    parameter int NUM_SAMPLES_LOG2 = DEF_NUM_SAMPLES_LOG2,
    parameter int LOW_THRESH       = DEF_LOW_THRESH,
    parameter int HIGH_THRESH      = DEF_HIGH_THRESH,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_measure_req,
    output logic                 o_adc_start,
    input  logic                 i_adc_done,
    input  logic [ADC_WIDTH-1:0] i_adc_data,
    output logic                 o_moisture_low,
    output logic [ADC_WIDTH-1:0] o_moisture_avg,
    output logic                 o_meas_valid,
    output logic                 o_meas_error,
    output logic                 o_busy
);

    // Sum of 2^N samples of ADC_WIDTH bits never overflows this width
    localparam int ACC_W = ADC_WIDTH + NUM_SAMPLES_LOG2;
    localparam int CNT_W = NUM_SAMPLES_LOG2 + 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << NUM_SAMPLES_LOG2) - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    meas_state_t          r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [TO_W-1:0]      r_tcnt;
    logic                 r_adc_start;
    logic                 r_moisture_low;
    logic [ADC_WIDTH-1:0] r_moisture_avg;
    logic                 r_meas_valid;
    logic                 r_meas_error;
    logic                 r_busy;

    logic [ADC_WIDTH-1:0] w_avg;
    logic                 w_next_low;
    logic                 w_last;

    // Truncating divide by the sample count is just dropping the low bits
    assign w_avg  = r_acc[ACC_W-1:NUM_SAMPLES_LOG2];
    assign w_last = (r_cnt == LAST_SAMPLE);

    moisture_hysteresis_cmp #(
        .ADC_WIDTH   (ADC_WIDTH),
        .LOW_THRESH  (LOW_THRESH),
        .HIGH_THRESH (HIGH_THRESH)
    ) u_cmp (
        .i_avg      (w_avg),
        .i_prev_low (r_moisture_low),
        .o_next_low (w_next_low)
    );

    // Measurement sequencer; every output is registered on the edge that enters its state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_tcnt         <= '0;
            r_adc_start    <= 1'b0;
            r_moisture_low <= MOISTURE_WET;
            r_moisture_avg <= '0;
            r_meas_valid   <= 1'b0;
            r_meas_error   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_adc_start  <= 1'b0;
            r_meas_valid <= 1'b0;
            r_meas_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_measure_req) begin
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_adc_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_tcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still counts as a sample
                    if (i_adc_done) begin
                        r_acc <= r_acc + ACC_W'(i_adc_data);
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_COMPARE;
                        end else begin
                            r_adc_start <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end else if (r_tcnt == TIMEOUT_MAX) begin
                        // Dead ADC: fall back to "not dry" so the pump stays off
                        r_moisture_low <= MOISTURE_WET;
                        r_meas_error   <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                ST_COMPARE: begin
                    r_moisture_low <= w_next_low;
                    r_moisture_avg <= w_avg;
                    r_meas_valid   <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_adc_start    = r_adc_start;
    assign o_moisture_low = r_moisture_low;
    assign o_moisture_avg = r_moisture_avg;
    assign o_meas_valid   = r_meas_valid;
    assign o_meas_error   = r_meas_error;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_soil_moisture_sensor_frontend.sv
// tb/tb_soil_moisture_sensor_frontend.sv - directed self-checking bench for the soil moisture frontend
module tb_soil_moisture_sensor_frontend;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       done;
    logic [9:0] data;
    logic       adc_start;
    logic       low;
    logic [9:0] avg;
    logic       valid;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_valid = 0;
    int n_error = 0;
    int cyc = 0;
    int t_req = 0;
    int t_valid = 0;

    soil_moisture_sensor_frontend #(
        .ADC_WIDTH        (10),
        .NUM_SAMPLES_LOG2 (2),
        .LOW_THRESH       (300),
        .HIGH_THRESH      (400),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_measure_req  (req),
        .o_adc_start    (adc_start),
        .i_adc_done     (done),
        .i_adc_data     (data),
        .o_moisture_low (low),
        .o_moisture_avg (avg),
        .o_meas_valid   (valid),
        .o_meas_error   (err),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (adc_start) n_start = n_start + 1;
        if (valid)     n_valid = n_valid + 1;
        if (err)       n_error = n_error + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int k = 0;
        while (!adc_start && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!adc_start) chk("adc_start_seen", 32'd0, 32'd1);
    endtask

    task automatic serve(input int d, input int delay, input bit early, input bit pulse);
        wait_start();
        if (early) begin
            done = 1'b1;
            data = 10'd1023;
        end
        @(negedge clk);
        done = 1'b0;
        if (pulse) req = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            if (pulse) req = 1'b0;
        end
        done = 1'b1;
        data = 10'(d);
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        t_valid = cyc;
        if (!valid) chk("meas_valid_seen", 32'd0, 32'd1);
    endtask

    task automatic measure(input int s0, input int s1, input int s2, input int s3, input bit hold);
        @(negedge clk);
        req = 1'b1;
        t_req = cyc;
        serve(s0, 0, 1'b0, 1'b0);
        if (!hold) req = 1'b0;
        serve(s1, 0, 1'b0, 1'b0);
        serve(s2, 0, 1'b0, 1'b0);
        serve(s3, 0, 1'b0, 1'b0);
        wait_valid();
    endtask

    initial begin
        int s0, v0, e0, k;
        rst_n = 1'b0;
        req   = 1'b0;
        done  = 1'b0;
        data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_low", 32'(low), 32'd0);
        chk("rst_avg", 32'(avg), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_error", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Dry soil: 200,250,300,250 -> 250, sets; minimum latency 2+2*4
        s0 = n_start; v0 = n_valid;
        measure(200, 250, 300, 250, 1'b0);
        chk("dry_avg", 32'(avg), 32'd250);
        chk("dry_low", 32'(low), 32'd1);
        chk("dry_latency", 32'(t_valid - t_req), 32'd10);
        @(negedge clk);
        chk("dry_valid_pulse", 32'(valid), 32'd0);
        chk("dry_busy_after", 32'(busy), 32'd0);
        chk("dry_start_count", 32'(n_start - s0), 32'd4);
        chk("dry_valid_count", 32'(n_valid - v0), 32'd1);

        // Reset mid-measurement
        s0 = n_start; v0 = n_valid; e0 = n_error;
        @(negedge clk);
        req = 1'b1;
        serve(200, 0, 1'b0, 1'b0);
        req = 1'b0;
        wait_start();
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_low", 32'(low), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_avg", 32'(avg), 32'd0);
        chk("midrst_start", 32'(adc_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid; e0 = n_error; s0 = n_start;
        repeat (10) @(negedge clk);
        chk("midrst_no_start", 32'(n_start - s0), 32'd0);
        chk("midrst_no_valid", 32'(n_valid - v0), 32'd0);
        chk("midrst_no_error", 32'(n_error - e0), 32'd0);

        // Inside the band from 0 holds 0
        measure(350, 350, 350, 350, 1'b0);
        chk("hold0_avg", 32'(avg), 32'd350);
        chk("hold0_low", 32'(low), 32'd0);

        // Truncation: 1199 -> 299 sets
        measure(299, 300, 300, 300, 1'b0);
        chk("trunc299_avg", 32'(avg), 32'd299);
        chk("trunc299_low", 32'(low), 32'd1);

        // Inside the band from 1 holds 1, then 400 clears
        measure(350, 350, 350, 350, 1'b0);
        chk("hold1_avg", 32'(avg), 32'd350);
        chk("hold1_low", 32'(low), 32'd1);
        measure(400, 400, 400, 400, 1'b0);
        chk("clear400_avg", 32'(avg), 32'd400);
        chk("clear400_low", 32'(low), 32'd0);

        // Truncation: 1603 -> 400 clears
        measure(250, 250, 250, 250, 1'b0);
        chk("reset250_low", 32'(low), 32'd1);
        measure(401, 401, 401, 400, 1'b0);
        chk("trunc400_avg", 32'(avg), 32'd400);
        chk("trunc400_low", 32'(low), 32'd0);

        // Timeout on the second sample after a dry result
        measure(200, 200, 200, 200, 1'b0);
        chk("pre_to_low", 32'(low), 32'd1);
        @(negedge clk);
        v0 = n_valid; e0 = n_error;
        req = 1'b1;
        serve(123, 0, 1'b0, 1'b0);
        req = 1'b0;
        wait_start();
        k = 0;
        while (!err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", 32'(k), 32'd17);
        chk("to_low", 32'(low), 32'd0);
        chk("to_avg", 32'(avg), 32'd200);
        chk("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'd0);
        chk("to_busy_next", 32'(busy), 32'd0);
        chk("to_error_count", 32'(n_error - e0), 32'd1);
        chk("to_no_valid", 32'(n_valid - v0), 32'd0);

        // adc_done during START ignored, measure_req during WAIT ignored
        s0 = n_start; v0 = n_valid;
        @(negedge clk);
        req = 1'b1;
        serve(100, 0, 1'b1, 1'b0);
        req = 1'b0;
        serve(100, 2, 1'b0, 1'b1);
        serve(100, 0, 1'b0, 1'b0);
        serve(100, 0, 1'b0, 1'b0);
        wait_valid();
        chk("hs_avg", 32'(avg), 32'd100);
        chk("hs_low", 32'(low), 32'd1);
        repeat (6) @(negedge clk);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_start_count", 32'(n_start - s0), 32'd4);
        chk("hs_valid_count", 32'(n_valid - v0), 32'd1);

        // adc_done exactly on the timeout cycle is accepted
        e0 = n_error;
        @(negedge clk);
        req = 1'b1;
        serve(500, 15, 1'b0, 1'b0);
        req = 1'b0;
        serve(500, 15, 1'b0, 1'b0);
        serve(500, 15, 1'b0, 1'b0);
        serve(500, 15, 1'b0, 1'b0);
        wait_valid();
        chk("edge_avg", 32'(avg), 32'd500);
        chk("edge_low", 32'(low), 32'd0);
        chk("edge_no_error", 32'(n_error - e0), 32'd0);

        // Back-to-back with measure_req held high
        measure(250, 250, 250, 250, 1'b1);
        chk("b2b_first_low", 32'(low), 32'd1);
        @(negedge clk);
        chk("b2b_rearm_start", 32'(adc_start), 32'd1);
        req = 1'b0;
        serve(400, 0, 1'b0, 1'b0);
        serve(400, 0, 1'b0, 1'b0);
        serve(400, 0, 1'b0, 1'b0);
        serve(400, 0, 1'b0, 1'b0);
        wait_valid();
        chk("b2b_second_avg", 32'(avg), 32'd400);
        chk("b2b_second_low", 32'(low), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
